// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit constants: FSM encodings and the NOP word,
// also used by the core's stall/trap logic.
package instr_fetch_unit_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-entry tagged buffer in front of a
// multi-cycle req/ack instruction memory.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic        buf_valid;
    logic [31:0] buf_tag;
    logic [31:0] buf_data;
    logic [1:0]  fsm;
    logic [7:0]  timeout_cnt;
    logic        req_stale;
    logic [31:0] fault_addr;

    logic hit;
    logic misaligned;

    assign misaligned  = |instr_addr[1:0];
    assign hit         = buf_valid && (buf_tag == instr_addr) && !flush;
    assign instr_valid = hit && !misaligned;
    assign instr       = instr_valid ? buf_data : NOP_INSTR;
    assign fetch_fault = misaligned ||
                         ((fsm == FAULT) && (instr_addr == fault_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
            buf_data    <= '0;
            fsm         <= IDLE;
            timeout_cnt <= '0;
            req_stale   <= 1'b0;
            fault_addr  <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
        end else begin
            if (flush) buf_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (!hit && !misaligned) begin
                        imem_req    <= 1'b1;
                        imem_addr   <= instr_addr;
                        timeout_cnt <= '0;
                        fsm         <= REQ;
                    end
                end
                REQ: begin
                    if (flush) req_stale <= 1'b1;
                    if (imem_ack) begin
                        imem_req  <= 1'b0;
                        req_stale <= 1'b0;
                        // A flush seen at any point of the request
                        // makes its data untrustworthy.
                        if (req_stale || flush) begin
                            fsm <= IDLE;
                        end else if (imem_err) begin
                            fsm        <= FAULT;
                            fault_addr <= imem_addr;
                        end else begin
                            buf_valid <= 1'b1;
                            buf_tag   <= imem_addr;
                            buf_data  <= imem_rdata;
                            fsm       <= IDLE;
                        end
                    end else if (timeout_cnt == CNT_LAST) begin
                        imem_req   <= 1'b0;
                        req_stale  <= 1'b0;
                        fsm        <= FAULT;
                        fault_addr <= imem_addr;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    if (instr_addr != fault_addr) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural
// wait-state / error / mute memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;

    instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr),
        .flush(flush), .instr(instr), .instr_valid(instr_valid),
        .fetch_fault(fetch_fault), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t sb[$];
    int checks = 0;
    int errors = 0;

    int          wait_st = 0;
    bit          mute = 1'b0;
    bit          late_ack = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          req_starts = 0;
    logic        req_q = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        req_q <= imem_req;
        if (imem_req && !req_q) req_starts <= req_starts + 1;
    end

    initial begin : mem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            imem_err = 1'b0;
            if (late_ack) begin
                late_ack   = 1'b0;
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req && !mute) begin
                if (cnt >= wait_st) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    imem_err   = err_en && (imem_addr == err_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic set_addr(input logic [31:0] a);
        fetch_t e;
        e.addr = a;
        e.data = mem_word(a);
        instr_addr = a;
        sb.push_back(e);
    endtask

    task automatic wait_fetch(input string tag, input int budget);
        fetch_t e;
        int n;
        n = 0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        while (!(instr_valid && instr_addr == e.addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_data"}, instr, e.data);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int starts0;

        // Reset state
        wait_st = 1;
        cycles(2);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);

        // First fetch of 0x0, one wait state: valid in cycle 3
        set_addr(32'h0);
        reset = 1'b0;
        cycles(1);
        check("c1_req", {31'd0, imem_req}, 32'd1);
        check("c1_instr", instr, NOP);
        cycles(1);
        check("c2_valid", {31'd0, instr_valid}, 32'd0);
        cycles(1);
        wait_fetch("c3_fetch0", 0);

        // Hold: hits, no requests
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_req", {31'd0, imem_req}, 32'd0);
        end

        // Address moves while 0x04 is outstanding
        wait_st = 3;
        instr_addr = 32'h04;
        cycles(1);
        check("mv_req", {31'd0, imem_req}, 32'd1);
        set_addr(32'h40);
        n = 0;
        while (imem_req && n < 10) begin
            cycles(1);
            n++;
            if (imem_req)
                check("mv_hold_addr", imem_addr, 32'h04);
            check("mv_no_valid", {31'd0, instr_valid}, 32'd0);
        end
        check("mv_req_drop", {31'd0, imem_req}, 32'd0);
        cycles(1);
        check("mv_rereq", {31'd0, imem_req}, 32'd1);
        check("mv_rereq_addr", imem_addr, 32'h40);
        wait_fetch("mv_fetch40", 10);

        // Bus error on 0x80
        wait_st = 0;
        err_en = 1'b1;
        err_addr = 32'h80;
        instr_addr = 32'h80;
        n = 0;
        while (!fetch_fault && n < 10) begin
            cycles(1);
            n++;
        end
        check("err_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("err_hold_fault", {31'd0, fetch_fault}, 32'd1);
            check("err_no_valid", {31'd0, instr_valid}, 32'd0);
            check("err_no_req", {31'd0, imem_req}, 32'd0);
        end
        set_addr(32'h100);
        #1;
        check("err_fault_clr", {31'd0, fetch_fault}, 32'd0);
        wait_fetch("err_fetch100", 10);
        err_en = 1'b0;

        // Timeout: request held exactly 4 cycles
        mute = 1'b1;
        instr_addr = 32'h200;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (imem_req) n++;
            else if (n > 0) break;
        end
        check("to_req_cycles", n, 32'd4);
        check("to_fault", {31'd0, fetch_fault}, 32'd1);
        cycles(2);
        late_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("to_late_valid", {31'd0, instr_valid}, 32'd0);
            check("to_late_fault", {31'd0, fetch_fault}, 32'd1);
        end
        mute = 1'b0;
        instr_addr = 32'h100;
        #1;
        check("to_buf_kept", {31'd0, instr_valid}, 32'd1);
        check("to_buf_data", instr, mem_word(32'h100));
        cycles(2);

        // Flush during outstanding request for 0x08
        wait_st = 2;
        starts0 = req_starts;
        set_addr(32'h08);
        n = 0;
        while (!imem_req && n < 10) begin
            cycles(1);
            n++;
        end
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        wait_fetch("fl_fetch08", 20);
        cycles(1);
        check("fl_req_count", req_starts - starts0, 32'd2);

        // Flush forces a miss in the same cycle
        flush = 1'b1;
        #1;
        check("fl_kill_hit", {31'd0, instr_valid}, 32'd0);
        check("fl_kill_instr", instr, NOP);
        cycles(1);
        flush = 1'b0;
        sb.push_back('{32'h08, mem_word(32'h08)});
        wait_fetch("fl_refetch08", 20);

        // Misaligned address
        cycles(1);
        instr_addr = 32'h02;
        #1;
        check("mis_fault", {31'd0, fetch_fault}, 32'd1);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("mis_no_req", {31'd0, imem_req}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
